if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, the instruction queue depth and maximum in-flight request count (range 2..8).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  32  fetch address, always word-aligned.
REQ-007 imem_req_ready  input  1  memory accepts request; handshake = valid & ready.
REQ-008 imem_resp_valid  input  1  in-order response valid; always accepted, no backpressure.
REQ-009 imem_resp_data  input  32  fetched instruction word.
REQ-010 stall  input  1  downstream IF/ID register holding; do not pop.
REQ-011 redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
REQ-012 redirect_pc  input  32  redirect target.
REQ-013 if_ins_out  output  32  instruction to IF/ID register.
REQ-014 if_pc_plus_4_out  output  32  address of if_ins_out plus 4.
REQ-015 if_valid  output  1  if_ins_out holds a real fetched instruction.

Function
REQ-016 PC register SHALL advance by 4 on each request handshake; 32-bit wrap, 0xFFFFFFFC -> 0x00000000.
REQ-017 imem_req_addr SHALL equal PC; imem_req_valid SHALL be 1 when inflight + occupancy < QDEPTH and redirect_valid = 0, else 0.
REQ-018 inflight counter SHALL increment on request handshake, decrement on imem_resp_valid, both in the same cycle -> unchanged.
REQ-019 An address FIFO (depth QDEPTH) SHALL record pc+4 of each issued request so each response is paired in order.
REQ-020 A response with drop_cnt = 0 SHALL be pushed into the instruction queue with its paired pc+4; with drop_cnt > 0 it SHALL be discarded and drop_cnt decremented.
REQ-021 Queue output SHALL be driven from head registers, changing only on clock edges; empty queue -> if_ins_out = 32'h00000013, if_pc_plus_4_out = 0, if_valid = 0.
REQ-022 Pop SHALL occur when stall = 0 and queue non-empty; stall = 1 holds all three outputs stable.
REQ-023 Push and pop in the same cycle SHALL keep occupancy unchanged; a push into an empty queue becomes visible on the next cycle (fetch latency: request handshake -> response cycle -> outputs valid one edge later).
REQ-024 Credit rule of REQ-017 SHALL guarantee the queue never overflows; overflow is unreachable.
REQ-025 On redirect_valid: PC <= {redirect_pc[31:2], 2'b00}; instruction queue and address FIFO contents flushed; drop_cnt <= inflight minus 1 if a response arrives that same cycle (that response also discarded).
REQ-026 Redirect SHALL take priority over stall and over any same-cycle push; no request issues in the redirect cycle.
REQ-027 redirect_pc[1:0] != 0 SHALL be silently truncated, no error.
REQ-028 Back-to-back redirects SHALL each reload PC and recompute drop_cnt from current inflight.
REQ-029 imem_resp_valid with inflight = 0 is a protocol violation; behaviour undefined, not checked.

Reset
REQ-030 rst = 1 SHALL immediately set PC = RESET_PC, inflight = 0, drop_cnt = 0, queues empty, imem_req_valid = 0, if_ins_out = 32'h00000013, if_pc_plus_4_out = 0, if_valid = 0.
REQ-031 Reset mid-operation SHALL abandon outstanding requests; responses arriving while rst = 1 SHALL be ignored.
REQ-032 First request SHALL be presented on the first rising edge after rst deasserts.

Verification
REQ-033 Reset release, ready = 1, 1-cycle memory returning 0x00A00093 -> addr 0x0, 0x4 issued; outputs 0x00A00093/0x00000004, if_valid = 1.
REQ-034 stall = 1 for 3 cycles with queue full (QDEPTH = 2) -> imem_req_valid = 0, outputs held, no lost or duplicated instruction after release.
REQ-035 redirect to 0x00000100 with 2 requests in flight -> both responses discarded, next if_pc_plus_4_out = 0x00000104, if_valid = 0 in between.
REQ-036 redirect_pc = 0x00000102 -> imem_req_addr = 0x00000100.
REQ-037 RESET_PC = 0xFFFFFFFC -> second request addr 0x00000000, first output if_pc_plus_4_out = 0x00000000.
REQ-038 rst asserted with 1 request in flight and queue non-empty -> outputs NOP/0/0 asynchronously; late response ignored.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response channels, pipeline
// control inputs and the instruction handed to the IF/ID register.
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_ins_out;
    logic [31:0] if_pc_plus_4_out;
    logic        if_valid;

    modport master (
        output imem_req_valid, imem_req_addr, if_ins_out, if_pc_plus_4_out, if_valid,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_ins_out, if_pc_plus_4_out, if_valid,
        output imem_req_ready, imem_resp_valid, imem_resp_data, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order response pairing
// with an address FIFO, instruction queue toward IF/ID, redirect flush/drop.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
);
    localparam int unsigned PW  = $clog2(QDEPTH);
    localparam int unsigned CW  = $clog2(QDEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
    } iq_entry_t;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] af_rd_q, af_rd_d, af_wr_q, af_wr_d;
    logic [PW-1:0] iq_rd_q, iq_rd_d, iq_wr_q, iq_wr_d;
    logic [CW-1:0] iq_cnt_q, iq_cnt_d;
    logic [31:0]   af_mem_q [QDEPTH];
    iq_entry_t     iq_mem_q [QDEPTH];

    logic [CW:0]   used;
    logic          credit, redir, req_fire, resp_keep, resp_drop, pop, head_vld;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Counting queued entries together with in-flight requests reserves a
    // queue slot for every response, so the queue can never overflow.
    assign redir     = bus.redirect_valid;
    assign used      = {1'b0, inflight_q} + {1'b0, iq_cnt_q};
    assign credit    = used < (CW+1)'(QDEPTH);
    assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
    assign resp_drop = bus.imem_resp_valid & (drop_q != '0);
    assign resp_keep = bus.imem_resp_valid & (drop_q == '0) & ~redir;
    assign pop       = ~bus.stall & (iq_cnt_q != '0) & ~redir;
    assign head_vld  = (iq_cnt_q != '0);

    assign bus.imem_req_valid   = ~rst & credit & ~redir;
    assign bus.imem_req_addr    = pc_q;
    assign bus.if_valid         = head_vld;
    assign bus.if_ins_out       = head_vld ? iq_mem_q[iq_rd_q].ins : NOP;
    assign bus.if_pc_plus_4_out = head_vld ? iq_mem_q[iq_rd_q].pc4 : 32'h0;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        af_rd_d    = af_rd_q;
        af_wr_d    = af_wr_q;
        iq_rd_d    = iq_rd_q;
        iq_wr_d    = iq_wr_q;
        iq_cnt_d   = iq_cnt_q;
        if (redir) begin
            // Everything still outstanding belongs to the old path; a response
            // landing this very cycle is consumed by the flush itself.
            pc_d       = {bus.redirect_pc[31:2], 2'b00};
            inflight_d = inflight_q - CW'(bus.imem_resp_valid);
            drop_d     = inflight_q - CW'(bus.imem_resp_valid);
            af_rd_d    = '0;
            af_wr_d    = '0;
            iq_rd_d    = '0;
            iq_wr_d    = '0;
            iq_cnt_d   = '0;
        end else begin
            if (req_fire) begin
                pc_d    = pc_q + 32'd4;
                af_wr_d = ptr_inc(af_wr_q);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
            if (resp_drop)
                drop_d = drop_q - CW'(1);
            if (resp_keep) begin
                af_rd_d = ptr_inc(af_rd_q);
                iq_wr_d = ptr_inc(iq_wr_q);
            end
            if (pop)
                iq_rd_d = ptr_inc(iq_rd_q);
            iq_cnt_d = iq_cnt_q + CW'(resp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            af_rd_q    <= '0;
            af_wr_q    <= '0;
            iq_rd_q    <= '0;
            iq_wr_q    <= '0;
            iq_cnt_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            af_rd_q    <= af_rd_d;
            af_wr_q    <= af_wr_d;
            iq_rd_q    <= iq_rd_d;
            iq_wr_q    <= iq_wr_d;
            iq_cnt_q   <= iq_cnt_d;
        end
    end

    // Storage needs no reset: pointers and counts decide what is live.
    always_ff @(posedge clk) begin
        if (req_fire)
            af_mem_q[af_wr_q] <= pc_q + 32'd4;
        if (resp_keep)
            iq_mem_q[iq_wr_q] <= '{ins: bus.imem_resp_data, pc4: af_mem_q[af_rd_q]};
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Random + directed bench for if_fetch_unit against a queue-based reference
// model; a second instance covers the RESET_PC wrap case.
module tb_if_fetch_unit;
    localparam int          QD  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct { logic [31:0] pc4; bit live; } oq_t;
    typedef struct { logic [31:0] ins; logic [31:0] pc4; } iq_t;
    typedef struct { logic [31:0] d; int due; } mq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    if_fetch_unit_if bus ();
    if_fetch_unit_if bus1 ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut  (.clk(clk), .rst(rst), .bus(bus));
    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(QD)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    int          n_chk = 0, n_err = 0, cyc = 0;
    int          lat_lo = 0, lat_hi = 0;
    bit          const_mode = 0;
    logic [31:0] m_pc = 32'h0;
    oq_t         oq[$];
    iq_t         iq[$];
    mq_t         mq[$];
    logic [31:0] cons[$], iss[$], b1_iss[$];
    logic [31:0] o_ins, o_pc4, o_addr, b1_pc4;
    logic        o_vld, o_rqv;
    bit          b1_got = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return const_mode ? 32'h00A0_0093 : ((a * 32'h9E37_79B1) ^ 32'h13);
    endfunction

    // One clock: check outputs, drive inputs, update the model at the edge.
    // Entered and left at a falling edge.
    task automatic tick(input logic stl, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic        rsp, exp_rv, fire, pop;
        logic [31:0] rdat;
        oq_t         e;
        o_ins = bus.if_ins_out;
        o_pc4 = bus.if_pc_plus_4_out;
        o_vld = bus.if_valid;
        chk("ins", o_ins, (iq.size() > 0) ? iq[0].ins : NOP);
        chk("pc4", o_pc4, (iq.size() > 0) ? iq[0].pc4 : 32'h0);
        chk("vld", o_vld, iq.size() > 0);
        if (o_vld && !stl && !rv) cons.push_back(o_pc4);
        bus.stall = stl;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.imem_req_ready = rdy;
        rsp = 1'b0;
        rdat = $urandom;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rsp = 1'b1;
            rdat = mq[0].d;
            void'(mq.pop_front());
        end
        bus.imem_resp_valid = rsp;
        bus.imem_resp_data = rdat;
        #1;
        exp_rv = !rv && (oq.size() + iq.size() < QD);
        o_rqv = bus.imem_req_valid;
        o_addr = bus.imem_req_addr;
        chk("rqv", o_rqv, exp_rv);
        if (exp_rv) chk("rqa", o_addr, m_pc);
        if (o_rqv && rdy) iss.push_back(o_addr);
        fire = exp_rv && rdy;
        pop = !stl && !rv && iq.size() > 0;
        @(posedge clk);
        cyc++;
        if (rv) begin
            m_pc = {rpc[31:2], 2'b00};
            iq.delete();
            foreach (oq[i]) oq[i].live = 0;
            if (rsp && oq.size() > 0) void'(oq.pop_front());
        end else begin
            if (pop) void'(iq.pop_front());
            if (rsp && oq.size() > 0) begin
                e = oq.pop_front();
                if (e.live) iq.push_back('{ins: rdat, pc4: e.pc4});
            end
            if (fire) begin
                mq.push_back('{d: memw(m_pc), due: cyc + int'($urandom_range(lat_hi, lat_lo))});
                oq.push_back('{pc4: m_pc + 32'd4, live: 1'b1});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    // Asserted at a falling edge; outputs must collapse before any clock.
    task automatic do_reset();
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        chk("rst_ins", bus.if_ins_out, NOP);
        chk("rst_pc4", bus.if_pc_plus_4_out, 32'h0);
        chk("rst_vld", bus.if_valid, 1'b0);
        chk("rst_rqv", bus.imem_req_valid, 1'b0);
        if (mq.size() > 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data = mq[0].d;
        end
        @(posedge clk);
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_pc = 32'h0;
        oq.delete();
        iq.delete();
        mq.delete();
        rst = 1'b0;
    endtask

    // Second instance: always-ready 1-cycle memory, records the first issues.
    initial begin
        logic        pend;
        logic [31:0] pdat;
        pend = 1'b0;
        pdat = 32'h0;
        bus1.imem_resp_valid = 1'b0;
        bus1.imem_resp_data = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                bus1.imem_resp_valid = 1'b0;
                pend = 1'b0;
            end else begin
                bus1.imem_resp_valid = pend;
                bus1.imem_resp_data = pdat;
                pend = bus1.imem_req_valid;
                pdat = ~bus1.imem_req_addr;
                if (bus1.imem_req_valid && b1_iss.size() < 2) b1_iss.push_back(bus1.imem_req_addr);
                if (bus1.if_valid && !b1_got) begin
                    b1_got = 1;
                    b1_pc4 = bus1.if_pc_plus_4_out;
                end
            end
        end
    end

    initial begin
        bit got;
        bus.imem_req_ready = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = 32'h0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus1.imem_req_ready = 1'b1;
        bus1.stall = 1'b0;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc = 32'h0;
        @(negedge clk);
        do_reset();

        // Boot with a 1-cycle memory returning a constant word.
        const_mode = 1;
        iss.delete();
        repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b1);
        chk("boot_a0", (iss.size() > 0) ? iss[0] : 32'hxxxx_xxxx, 32'h0);
        chk("boot_a1", (iss.size() > 1) ? iss[1] : 32'hxxxx_xxxx, 32'h4);
        chk("boot_ins", o_ins, 32'h00A0_0093);
        chk("boot_pc4", o_pc4, 32'h4);
        chk("boot_vld", o_vld, 1'b1);
        const_mode = 0;

        // Fill the queue under stall, hold, then drain in order.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1);
            if (i >= 3) begin
                chk("hold_rqv", o_rqv, 1'b0);
                chk("hold_pc4", o_pc4, 32'h4);
            end
        end
        cons.delete();
        repeat (10) tick(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++)
            chk("drain_seq", (cons.size() > i) ? cons[i] : 32'hxxxx_xxxx, 32'(4 * (i + 1)));

        // Redirect with two requests outstanding.
        do_reset();
        lat_lo = 2;
        lat_hi = 2;
        repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            if (o_vld) begin
                got = 1;
                chk("redir_pc4", o_pc4, 32'h0000_0104);
            end
        end
        chk("redir_seen", got, 1'b1);

        // Misaligned redirect target.
        tick(1'b0, 1'b1, 32'h0000_0102, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        chk("redir_align", o_addr, 32'h0000_0100);

        // Reset with one request in flight and a queued instruction.
        do_reset();
        lat_lo = 0;
        lat_hi = 0;
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        lat_lo = 3;
        lat_hi = 3;
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b0);
        chk("late_vld", o_vld, 1'b0);

        // Randomized traffic, including wrap-region redirects and resets.
        lat_lo = 0;
        lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            logic        rv;
            logic [31:0] rpc;
            rv = ($urandom_range(99) < 5);
            rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            if ($urandom_range(499) == 0) do_reset();
            else tick($urandom_range(99) < 30, rv, rpc, $urandom_range(99) < 75);
        end

        chk("wrap_a0", (b1_iss.size() > 0) ? b1_iss[0] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
        chk("wrap_a1", (b1_iss.size() > 1) ? b1_iss[1] : 32'hxxxx_xxxx, 32'h0);
        chk("wrap_pc4", b1_got ? b1_pc4 : 32'hxxxx_xxxx, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
